dual_hazard_stall_unit: RTL and testbench
=========================================

# dual_hazard_stall_unit

Stall, split-issue and flush controller for the dual-issue pipeline. It covers the hazards that the forwarding paths cannot resolve: load-use dependencies, intra-pair RAW or memory-port conflicts, and taken branches resolved in MEM. It sits beside the ID stage and drives the PC, IF/ID and ID/EX write-enable, bubble and flush controls. The forwarding units treat every instruction this block lets through as hazard-free.

## Interface
- LOAD_STALL_CYCLES, 1: stall cycles inserted per load-use hazard (1..7).
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- Rs_id_inst1, Rt_id_inst1, Rs_id_inst2, Rt_id_inst2  in  5 each  ID-stage source registers.
- UseRs_id_inst1, UseRt_id_inst1, UseRs_id_inst2, UseRt_id_inst2  in  1 each  source actually read.
- RegWriteEn_id_inst1  in  1  lane-1 ID instruction writes a register.
- Dest_id_inst1  in  5  lane-1 ID destination register.
- MemAcc_id_inst1, MemAcc_id_inst2  in  1 each  ID instruction is a load or store.
- MemRead_ex_inst1, MemRead_ex_inst2  in  1 each  EX instruction is a load.
- Dest_ex_inst1, Dest_ex_inst2  in  5 each  EX destination registers.
- BranchTaken_mem_inst1, BranchTaken_mem_inst2  in  1 each  branch resolved taken in MEM.
- PCWriteEn  out  1  PC update enable.
- IFIDWriteEn  out  1  IF/ID register enable.
- IDEXBubble  out  2  per-lane ID/EX bubble; bit0 = lane 1, bit1 = lane 2.
- SplitIssue  out  1  high while lane 2's instruction issues alone.
- FlushIFID, FlushIDEX  out  1 each  flush the IF/ID and ID/EX registers.
- KillMem_inst2  out  1  squash lane 2 in MEM.
- StallCount  out  32  perf counter; present only with HAZARD_PERF_EN.

## Operation
- FSM states: RUN, LOAD_STALL, SPLIT.
- Down-counter `cnt` is 3 bits wide.
- All control outputs are combinational from the current state and inputs.
- The state, `cnt` and StallCount are registered.

**Hazard terms**
- ldhaz(S) = for either lane k: MemRead_ex_instk, Dest_ex_instk != 0, and Dest_ex_instk equals a used source in set S.
- pairhaz = either of:
  - RegWriteEn_id_inst1, Dest_id_inst1 != 0, and Dest_id_inst1 equals a used inst2 source;
  - MemAcc_id_inst1 && MemAcc_id_inst2.

**Priority:** branch flush > load stall > split.

**Branch flush** (any state), when either BranchTaken_mem is high:
- FlushIFID = FlushIDEX = 1, PCWriteEn = 1, IFIDWriteEn = 1, IDEXBubble = 0.
- KillMem_inst2 = BranchTaken_mem_inst1; there are no delay slots.
- Next state RUN, `cnt` cleared.

**RUN**
- ldhaz over all four ID sources:
  - PCWriteEn = 0, IFIDWriteEn = 0, IDEXBubble = 2'b11.
  - Next state LOAD_STALL with `cnt` = LOAD_STALL_CYCLES-2 if LOAD_STALL_CYCLES > 1; otherwise stay in RUN.
- Else pairhaz:
  - PCWriteEn = 0, IFIDWriteEn = 0, IDEXBubble = 2'b10; lane 1 issues.
  - Next state SPLIT.
- Else all enables 1, bubbles 0.

**LOAD_STALL**
- PCWriteEn = 0, IFIDWriteEn = 0, IDEXBubble = 2'b11.
- If `cnt` == 0, go to RUN; else decrement `cnt`.

**SPLIT**
- SplitIssue = 1.
- ldhaz over inst2 sources only: stall as above (IDEXBubble = 2'b11) and stay in SPLIT.
- Otherwise: PCWriteEn = 1, IFIDWriteEn = 1, IDEXBubble = 2'b01; lane 2 issues alone. Next state RUN.

**Register 0** never creates a hazard.

## Timing
- **Reset:** state RUN, `cnt` = 0, StallCount = 0. With inputs low: PCWriteEn = IFIDWriteEn = 1; IDEXBubble, SplitIssue, FlushIFID, FlushIDEX and KillMem_inst2 all 0.
- **Load-use:** the hazard is detected in the cycle the load is in EX. It costs exactly LOAD_STALL_CYCLES stall cycles, after which the consumer reaches EX with the load in MEM or later.
- **Split issue:** costs exactly 1 cycle.
- **Flush:** same cycle as the branch assertion. It aborts LOAD_STALL or SPLIT immediately, and the next cycle is RUN with no residual stall.
- **Reset mid-stall:** reset asserted during LOAD_STALL or SPLIT returns to RUN asynchronously; the outputs revert to their reset values immediately.

## Configuration
- HAZARD_PERF_EN defined:
  - StallCount increments by 1 on every clk edge where PCWriteEn == 0 while rst is high.
  - It wraps at 2^32 and is cleared by reset.
- Undefined: the StallCount port and its register are absent.

## Test plan
- Load to r5 in EX lane 1; ID inst1 uses r5 as Rs; LOAD_STALL_CYCLES = 1 -> one cycle of PCWriteEn = 0, IDEXBubble = 2'b11, then enables return to 1.
- LOAD_STALL_CYCLES = 3 with the same hazard -> exactly 3 stall cycles; StallCount advances by 3.
- ID inst1 writes r8, inst2 reads r8 -> cycle 1 IDEXBubble = 2'b10, PCWriteEn = 0; cycle 2 SplitIssue = 1, IDEXBubble = 2'b01; cycle 3 RUN.
- Load to r0 in EX, ID reads r0; separately MemAcc on both ID lanes -> no load stall for r0; the MemAcc pair splits.
- BranchTaken_mem_inst1 asserted during the second LOAD_STALL cycle -> same cycle FlushIFID = FlushIDEX = KillMem_inst2 = 1, PCWriteEn = 1; next cycle RUN.
- rst pulled low during SPLIT -> immediately SplitIssue = 0 and PCWriteEn = 1; StallCount = 0.

Source files
------------

// File: rtl/dual_hazard_stall_unit_if.sv
// dual_hazard_stall_unit_if: hazard-unit signal bundle between the ID/EX/MEM stages and the stall controller
// Ports: none; the bundle carries the ID sources/destinations, EX load info, MEM branch outcomes
// (driven by master) and the PC/IFID/IDEX control outputs (driven by slave).
// StallCount exists only when HAZARD_PERF_EN is defined.
interface dual_hazard_stall_unit_if;
    logic [4:0] Rs_id_inst1, Rt_id_inst1, Rs_id_inst2, Rt_id_inst2;
    logic       UseRs_id_inst1, UseRt_id_inst1, UseRs_id_inst2, UseRt_id_inst2;
    logic       RegWriteEn_id_inst1;
    logic [4:0] Dest_id_inst1;
    logic       MemAcc_id_inst1, MemAcc_id_inst2;
    logic       MemRead_ex_inst1, MemRead_ex_inst2;
    logic [4:0] Dest_ex_inst1, Dest_ex_inst2;
    logic       BranchTaken_mem_inst1, BranchTaken_mem_inst2;
    logic       PCWriteEn, IFIDWriteEn;
    logic [1:0] IDEXBubble;
    logic       SplitIssue, FlushIFID, FlushIDEX, KillMem_inst2;
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCount;
`endif

    modport master (
        output Rs_id_inst1, Rt_id_inst1, Rs_id_inst2, Rt_id_inst2,
        output UseRs_id_inst1, UseRt_id_inst1, UseRs_id_inst2, UseRt_id_inst2,
        output RegWriteEn_id_inst1, Dest_id_inst1, MemAcc_id_inst1, MemAcc_id_inst2,
        output MemRead_ex_inst1, MemRead_ex_inst2, Dest_ex_inst1, Dest_ex_inst2,
        output BranchTaken_mem_inst1, BranchTaken_mem_inst2,
`ifdef HAZARD_PERF_EN
        input  StallCount,
`endif
        input  PCWriteEn, IFIDWriteEn, IDEXBubble, SplitIssue, FlushIFID, FlushIDEX, KillMem_inst2
    );

    modport slave (
        input  Rs_id_inst1, Rt_id_inst1, Rs_id_inst2, Rt_id_inst2,
        input  UseRs_id_inst1, UseRt_id_inst1, UseRs_id_inst2, UseRt_id_inst2,
        input  RegWriteEn_id_inst1, Dest_id_inst1, MemAcc_id_inst1, MemAcc_id_inst2,
        input  MemRead_ex_inst1, MemRead_ex_inst2, Dest_ex_inst1, Dest_ex_inst2,
        input  BranchTaken_mem_inst1, BranchTaken_mem_inst2,
`ifdef HAZARD_PERF_EN
        output StallCount,
`endif
        output PCWriteEn, IFIDWriteEn, IDEXBubble, SplitIssue, FlushIFID, FlushIDEX, KillMem_inst2
    );
endinterface

// File: rtl/dual_hazard_stall_unit.sv
// dual_hazard_stall_unit: load-use stall, intra-pair split-issue and branch-flush controller for the dual-issue pipeline
// Ports:
//   clk  - pipeline clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - dual_hazard_stall_unit_if.slave: ID/EX/MEM hazard inputs, PC/IFID/IDEX control outputs
// Parameter LOAD_STALL_CYCLES (1..7): stall cycles per load-use hazard.
// Optional macro HAZARD_PERF_EN: adds the 32-bit StallCount perf counter (cycles with PCWriteEn low).
module dual_hazard_stall_unit #(
    parameter int LOAD_STALL_CYCLES = 1
) (
    input logic clk,
    input logic rst,
    dual_hazard_stall_unit_if.slave bus
);
    typedef enum logic [1:0] {RUN, LOAD_STALL, SPLIT} state_t;

    // The RUN cycle that detects the hazard is the first stall cycle, so
    // LOAD_STALL only has to cover the remaining LOAD_STALL_CYCLES-1.
    localparam logic [2:0] LOAD_CNT = LOAD_STALL_CYCLES > 1 ? 3'(LOAD_STALL_CYCLES - 2) : 3'd0;

    state_t     state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic       pc_we, ifid_we, split, flush, kill;
    logic [1:0] bubble;
    logic [1:0] ld_i1, ld_i2;
    logic       ld_all, ld2, pair_haz, branch;

    function automatic logic src_hit(input logic mr, input logic [4:0] d,
                                     input logic u_rs, input logic [4:0] rs,
                                     input logic u_rt, input logic [4:0] rt);
        return mr && d != 5'd0 && ((u_rs && rs == d) || (u_rt && rt == d));
    endfunction

    // Per EX lane: does its load feed a used source of ID inst1 / inst2
    assign ld_i1[0] = src_hit(bus.MemRead_ex_inst1, bus.Dest_ex_inst1, bus.UseRs_id_inst1, bus.Rs_id_inst1, bus.UseRt_id_inst1, bus.Rt_id_inst1);
    assign ld_i1[1] = src_hit(bus.MemRead_ex_inst2, bus.Dest_ex_inst2, bus.UseRs_id_inst1, bus.Rs_id_inst1, bus.UseRt_id_inst1, bus.Rt_id_inst1);
    assign ld_i2[0] = src_hit(bus.MemRead_ex_inst1, bus.Dest_ex_inst1, bus.UseRs_id_inst2, bus.Rs_id_inst2, bus.UseRt_id_inst2, bus.Rt_id_inst2);
    assign ld_i2[1] = src_hit(bus.MemRead_ex_inst2, bus.Dest_ex_inst2, bus.UseRs_id_inst2, bus.Rs_id_inst2, bus.UseRt_id_inst2, bus.Rt_id_inst2);
    assign ld_all   = |{ld_i1, ld_i2};
    assign ld2      = |ld_i2;
    assign branch   = bus.BranchTaken_mem_inst1 || bus.BranchTaken_mem_inst2;
    assign pair_haz = src_hit(bus.RegWriteEn_id_inst1, bus.Dest_id_inst1, bus.UseRs_id_inst2, bus.Rs_id_inst2, bus.UseRt_id_inst2, bus.Rt_id_inst2)
                   || (bus.MemAcc_id_inst1 && bus.MemAcc_id_inst2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pc_we    = 1'b1;
        ifid_we  = 1'b1;
        bubble   = 2'b00;
        split    = 1'b0;
        flush    = 1'b0;
        kill     = 1'b0;
        if (branch) begin
            // Taken branch wins over any stall; lane 2 in MEM is younger than a taken lane-1 branch
            flush    = 1'b1;
            kill     = bus.BranchTaken_mem_inst1;
            state_nx = RUN;
            cnt_nx   = 3'd0;
        end else begin
            case (state)
                RUN: begin
                    if (ld_all) begin
                        pc_we   = 1'b0;
                        ifid_we = 1'b0;
                        bubble  = 2'b11;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_nx = LOAD_STALL;
                            cnt_nx   = LOAD_CNT;
                        end
                    end else if (pair_haz) begin
                        pc_we    = 1'b0;
                        ifid_we  = 1'b0;
                        bubble   = 2'b10;
                        state_nx = SPLIT;
                    end
                end
                LOAD_STALL: begin
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                    bubble  = 2'b11;
                    if (cnt == 3'd0) state_nx = RUN;
                    else cnt_nx = cnt - 3'd1;
                end
                SPLIT: begin
                    split = 1'b1;
                    if (ld2) begin
                        pc_we   = 1'b0;
                        ifid_we = 1'b0;
                        bubble  = 2'b11;
                    end else begin
                        bubble   = 2'b01;
                        state_nx = RUN;
                    end
                end
                default: state_nx = RUN;
            endcase
        end
    end

    assign bus.PCWriteEn     = pc_we;
    assign bus.IFIDWriteEn   = ifid_we;
    assign bus.IDEXBubble    = bubble;
    assign bus.SplitIssue    = split;
    assign bus.FlushIFID     = flush;
    assign bus.FlushIDEX     = flush;
    assign bus.KillMem_inst2 = kill;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_count <= 32'd0;
        else if (!pc_we) stall_count <= stall_count + 32'd1;
    end

    assign bus.StallCount = stall_count;
`endif
endmodule

// File: tb/tb_dual_hazard_stall_unit.sv
// tb_dual_hazard_stall_unit: directed plus random checks of two hazard units (LOAD_STALL_CYCLES 1 and 3) against a cycle-count model
module tb_dual_hazard_stall_unit;
    typedef struct packed {
        logic [4:0] rs1, rt1, rs2, rt2;
        logic       urs1, urt1, urs2, urt2;
        logic       we1;
        logic [4:0] d1;
        logic       ma1, ma2, mr1, mr2;
        logic [4:0] dx1, dx2;
        logic       bt1, bt2;
    } in_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    in_t         cur = '0;
    logic [7:0]  ctl_o [2];
    logic [31:0] cnt_o [2];
    int          total = 0;
    int          bad = 0;
    int          stall_left [2];
    bit          pending [2];
    int unsigned scount [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        dual_hazard_stall_unit_if bus();
        dual_hazard_stall_unit #(.LOAD_STALL_CYCLES(g == 0 ? 1 : 3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
        assign bus.Rs_id_inst1 = cur.rs1;
        assign bus.Rt_id_inst1 = cur.rt1;
        assign bus.Rs_id_inst2 = cur.rs2;
        assign bus.Rt_id_inst2 = cur.rt2;
        assign bus.UseRs_id_inst1 = cur.urs1;
        assign bus.UseRt_id_inst1 = cur.urt1;
        assign bus.UseRs_id_inst2 = cur.urs2;
        assign bus.UseRt_id_inst2 = cur.urt2;
        assign bus.RegWriteEn_id_inst1 = cur.we1;
        assign bus.Dest_id_inst1 = cur.d1;
        assign bus.MemAcc_id_inst1 = cur.ma1;
        assign bus.MemAcc_id_inst2 = cur.ma2;
        assign bus.MemRead_ex_inst1 = cur.mr1;
        assign bus.MemRead_ex_inst2 = cur.mr2;
        assign bus.Dest_ex_inst1 = cur.dx1;
        assign bus.Dest_ex_inst2 = cur.dx2;
        assign bus.BranchTaken_mem_inst1 = cur.bt1;
        assign bus.BranchTaken_mem_inst2 = cur.bt2;
        assign ctl_o[g] = {bus.PCWriteEn, bus.IFIDWriteEn, bus.IDEXBubble, bus.SplitIssue, bus.FlushIFID, bus.FlushIDEX, bus.KillMem_inst2};
`ifdef HAZARD_PERF_EN
        assign cnt_o[g] = bus.StallCount;
`else
        assign cnt_o[g] = 32'd0;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit ld_from(input int first);
        logic [4:0] src [4];
        bit         used [4];
        src  = '{cur.rs1, cur.rt1, cur.rs2, cur.rt2};
        used = '{cur.urs1, cur.urt1, cur.urs2, cur.urt2};
        for (int k = 0; k < 2; k++) begin
            logic       mr;
            logic [4:0] d;
            mr = k == 0 ? cur.mr1 : cur.mr2;
            d  = k == 0 ? cur.dx1 : cur.dx2;
            for (int s = first; s < 4; s++)
                if (mr && d != 5'd0 && used[s] && src[s] == d) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            stall_left[i] = 0;
            pending[i]    = 1'b0;
            scount[i]     = 0;
        end
    endfunction

    // Expected outputs packed as {PCWriteEn, IFIDWriteEn, IDEXBubble[1:0], SplitIssue, FlushIFID, FlushIDEX, KillMem_inst2}
    task automatic step();
        bit ld_all, ld2, pair, br;
        ld_all = ld_from(0);
        ld2    = ld_from(2);
        pair   = (cur.we1 && cur.d1 != 5'd0 && ((cur.urs2 && cur.rs2 == cur.d1) || (cur.urt2 && cur.rt2 == cur.d1))) || (cur.ma1 && cur.ma2);
        br     = cur.bt1 || cur.bt2;
        for (int i = 0; i < 2; i++) begin
            logic [7:0] e, mask;
            int         n;
            n = i == 0 ? 1 : 3;
            e = 8'b1100_0000;
            if (br) begin
                e = {7'b1100_011, cur.bt1};
                stall_left[i] = 0;
                pending[i]    = 1'b0;
            end else if (stall_left[i] > 0) begin
                e = 8'b0011_0000;
                stall_left[i]--;
            end else if (pending[i]) begin
                if (ld2) e = 8'b0011_1000;
                else begin
                    e = 8'b1101_1000;
                    pending[i] = 1'b0;
                end
            end else if (ld_all) begin
                e = 8'b0011_0000;
                stall_left[i] = n - 1;
            end else if (pair) begin
                e = 8'b0010_0000;
                pending[i] = 1'b1;
            end
            // SplitIssue is not constrained while a flush is in progress
            mask = br ? 8'b1111_0111 : 8'hFF;
            check(i == 0 ? "ctl_n1" : "ctl_n3", {24'd0, ctl_o[i] & mask}, {24'd0, e & mask});
`ifdef HAZARD_PERF_EN
            check(i == 0 ? "stallcnt_n1" : "stallcnt_n3", cnt_o[i], scount[i]);
`endif
            if (!e[7]) scount[i]++;
        end
    endtask

    task automatic cycle(input in_t v);
        @(negedge clk);
        cur = v;
        #1;
        step();
    endtask

    function automatic in_t rnd();
        in_t v;
        v.rs1 = 5'($urandom_range(0, 3)); v.rt1 = 5'($urandom_range(0, 3));
        v.rs2 = 5'($urandom_range(0, 3)); v.rt2 = 5'($urandom_range(0, 3));
        v.urs1 = 1'($urandom); v.urt1 = 1'($urandom); v.urs2 = 1'($urandom); v.urt2 = 1'($urandom);
        v.we1 = 1'($urandom); v.d1 = 5'($urandom_range(0, 3));
        v.ma1 = $urandom_range(0, 3) == 0; v.ma2 = $urandom_range(0, 3) == 0;
        v.mr1 = $urandom_range(0, 2) == 0; v.mr2 = $urandom_range(0, 2) == 0;
        v.dx1 = 5'($urandom_range(0, 3)); v.dx2 = 5'($urandom_range(0, 3));
        v.bt1 = $urandom_range(0, 9) == 0; v.bt2 = $urandom_range(0, 9) == 0;
        return v;
    endfunction

    initial begin
        in_t ld5, pr8, v;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        cycle('0);

        ld5 = '0; ld5.mr1 = 1'b1; ld5.dx1 = 5'd5; ld5.rs1 = 5'd5; ld5.urs1 = 1'b1;
        cycle(ld5);
        repeat (4) cycle('0);

        pr8 = '0; pr8.we1 = 1'b1; pr8.d1 = 5'd8; pr8.rs2 = 5'd8; pr8.urs2 = 1'b1;
        cycle(pr8);
        repeat (2) cycle('0);

        v = '0; v.mr1 = 1'b1; v.mr2 = 1'b1; v.rs1 = 5'd0; v.urs1 = 1'b1; v.rt2 = 5'd0; v.urt2 = 1'b1;
        cycle(v);
        v = '0; v.ma1 = 1'b1; v.ma2 = 1'b1;
        cycle(v);
        repeat (2) cycle('0);

        cycle(ld5);
        v = '0; v.bt1 = 1'b1;
        cycle(v);
        repeat (2) cycle('0);

        cycle(pr8);
        v = '0; v.mr1 = 1'b1; v.dx1 = 5'd9; v.rs2 = 5'd9; v.urs2 = 1'b1;
        cycle(v);
        @(posedge clk);
        #1 cur = '0;
        #1;
        check("split_hold_n1", {24'd0, ctl_o[0]}, 32'hD8);
        check("split_hold_n3", {24'd0, ctl_o[1]}, 32'hD8);
        rst = 1'b0;
        #1;
        check("rst_split_n1", {24'd0, ctl_o[0]}, 32'hC0);
        check("rst_split_n3", {24'd0, ctl_o[1]}, 32'hC0);
`ifdef HAZARD_PERF_EN
        check("rst_cnt_n3", cnt_o[1], 32'd0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        for (int t = 0; t < 600; t++) cycle(rnd());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
